// File: rtl/sn2bn_if.sv
// sn2bn_if: start/stop framing, serial stochastic input and the three result formats.
`default_nettype none

interface sn2bn_if #(
  parameter int SN_LEN = 16,
  parameter int BN_W   = 4
);
  localparam int CNT_W = $clog2(SN_LEN) + 1;

  logic             i_start_sn2bn;
  logic             i_stop_sn2bn;
  logic             i_sn_bit;
  logic             o_busy_sn2bn;
  logic             o_valid_sn2bn;
  logic [CNT_W-1:0] o_bn_cnt;
  logic [BN_W-1:0]  o_bn_sat;
  logic [CNT_W:0]   o_bn_bip;

  modport master (
    output i_start_sn2bn, i_stop_sn2bn, i_sn_bit,
    input  o_busy_sn2bn, o_valid_sn2bn, o_bn_cnt, o_bn_sat, o_bn_bip
  );

  modport slave (
    input  i_start_sn2bn, i_stop_sn2bn, i_sn_bit,
    output o_busy_sn2bn, o_valid_sn2bn, o_bn_cnt, o_bn_sat, o_bn_bip
  );
endinterface

`default_nettype wire

// File: rtl/sn2bn_counter.sv
// sn2bn_counter: counts ones of a stochastic stream over SN_LEN cycles and
// registers the result as raw count, saturated BN_W-bit value and bipolar value.
`default_nettype none

module sn2bn_counter #(
  parameter int SN_LEN = 16,
  parameter int BN_W   = 4
) (
  input  wire       i_clk_sn2bn,
  input  wire       i_rst_n_sn2bn,
  sn2bn_if.slave    bus
);
  localparam int CNT_W = $clog2(SN_LEN) + 1;
  localparam int IDX_W = $clog2(SN_LEN);
  localparam int EXT_W = CNT_W + BN_W;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SN_LEN - 1);
  localparam logic [EXT_W-1:0] SAT_MAX  = EXT_W'((1 << BN_W) - 1);
  localparam logic [CNT_W:0]   BIP_OFS  = (CNT_W + 1)'(SN_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic             load;

  logic [CNT_W-1:0] cnt_q;
  logic [BN_W-1:0]  sat_q;
  logic [CNT_W:0]   bip_q;

  // Final sum includes the bit sampled on the closing edge of the window.
  logic [CNT_W-1:0] sum;
  logic [EXT_W-1:0] sum_ext;
  logic [BN_W-1:0]  sum_sat;
  logic [CNT_W:0]   sum_bip;

  assign sum     = count + CNT_W'(bus.i_sn_bit);
  assign sum_ext = EXT_W'(sum);
  assign sum_sat = (sum_ext > SAT_MAX) ? SAT_MAX[BN_W-1:0] : sum_ext[BN_W-1:0];
  assign sum_bip = {sum, 1'b0} - BIP_OFS;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    idx_nxt   = idx;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.i_stop_sn2bn && bus.i_start_sn2bn) begin
          state_nxt = COUNT;
          count_nxt = '0;
          idx_nxt   = '0;
        end
      end
      COUNT: begin
        if (bus.i_stop_sn2bn) begin
          state_nxt = IDLE;
          count_nxt = '0;
          idx_nxt   = '0;
        end else if (bus.i_start_sn2bn) begin
          count_nxt = '0;
          idx_nxt   = '0;
        end else if (idx == IDX_LAST) begin
          state_nxt = DONE;
          load      = 1'b1;
          count_nxt = '0;
          idx_nxt   = '0;
        end else begin
          count_nxt = sum;
          idx_nxt   = idx + 1'b1;
        end
      end
      DONE: begin
        if (!bus.i_stop_sn2bn && bus.i_start_sn2bn) begin
          state_nxt = COUNT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
        idx_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk_sn2bn or negedge i_rst_n_sn2bn) begin
    if (!i_rst_n_sn2bn) begin
      state <= IDLE;
      count <= '0;
      idx   <= '0;
      cnt_q <= '0;
      sat_q <= '0;
      bip_q <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      idx   <= idx_nxt;
      if (load) begin
        cnt_q <= sum;
        sat_q <= sum_sat;
        bip_q <= sum_bip;
      end
    end
  end

  assign bus.o_busy_sn2bn  = (state == COUNT);
  assign bus.o_valid_sn2bn = (state == DONE);
  assign bus.o_bn_cnt      = cnt_q;
  assign bus.o_bn_sat      = sat_q;
  assign bus.o_bn_bip      = bip_q;

endmodule

`default_nettype wire

// File: tb/tb_sn2bn_counter.sv
// tb_sn2bn_counter: table-driven windows plus directed abort/restart/back-to-back/reset sequences.
`default_nettype none

module tb_sn2bn_counter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_valid = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sn2bn_if #(.SN_LEN(16), .BN_W(4)) bus ();

  sn2bn_counter #(.SN_LEN(16), .BN_W(4)) dut (
    .i_clk_sn2bn   (clk),
    .i_rst_n_sn2bn (rst_n),
    .bus           (bus.slave)
  );

  typedef struct {
    logic [15:0] bits;
    int          cnt;
    int          sat;
    int          bip;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string name, input int ecnt, input int esat, input int ebip);
    chk({name, "_cnt"}, int'(bus.o_bn_cnt), ecnt);
    chk({name, "_sat"}, int'(bus.o_bn_sat), esat);
    chk({name, "_bip"}, int'($signed(bus.o_bn_bip)), ebip);
  endtask

  // Start pulse at edge k, bits[i] sampled at edge k+1+i, result checked after edge k+16.
  task automatic run_window(input logic [15:0] bits, input int ecnt, input int esat,
                            input int ebip, input string tag);
    int early_valid;
    early_valid = 0;
    bus.i_start_sn2bn = 1'b1;
    @(posedge clk); #1;
    bus.i_start_sn2bn = 1'b0;
    bus.i_sn_bit = bits[0];
    chk({tag, "_busy_start"}, int'(bus.o_busy_sn2bn), 1);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (i < 15) begin
        if (bus.o_valid_sn2bn || !bus.o_busy_sn2bn) early_valid++;
        bus.i_sn_bit = bits[i+1];
      end
    end
    chk({tag, "_early_valid_or_idle"}, early_valid, 0);
    chk({tag, "_valid"}, int'(bus.o_valid_sn2bn), 1);
    chk({tag, "_busy_done"}, int'(bus.o_busy_sn2bn), 0);
    chk_outs(tag, ecnt, esat, ebip);
    last_valid = cyc;
    bus.i_sn_bit = 1'b0;
  endtask

  // Drive idle cycles and report any valid pulse seen.
  task automatic idle_cycles(input int n, input logic bit_val, input string tag);
    int seen;
    seen = 0;
    bus.i_sn_bit = bit_val;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      if (bus.o_valid_sn2bn || bus.o_busy_sn2bn) seen++;
    end
    chk({tag, "_quiet"}, seen, 0);
    bus.i_sn_bit = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{16'h0000,  0,  0, -16};
    vecs[1]  = '{16'h0001,  1,  1, -14};
    vecs[2]  = '{16'h8001,  2,  2, -12};
    vecs[3]  = '{16'h0700,  3,  3, -10};
    vecs[4]  = '{16'hF000,  4,  4,  -8};
    vecs[5]  = '{16'h001F,  5,  5,  -6};
    vecs[6]  = '{16'h0C3C,  6,  6,  -4};
    vecs[7]  = '{16'h7F00,  7,  7,  -2};
    vecs[8]  = '{16'hAAAA,  8,  8,   0};
    vecs[9]  = '{16'h01FF,  9,  9,   2};
    vecs[10] = '{16'h03FF, 10, 10,   4};
    vecs[11] = '{16'hF0F7, 11, 11,   6};
    vecs[12] = '{16'h0FFF, 12, 12,   8};
    vecs[13] = '{16'hFFF8, 13, 13,  10};
    vecs[14] = '{16'h7FFE, 14, 14,  12};
    vecs[15] = '{16'hFFFE, 15, 15,  14};
    vecs[16] = '{16'hFFFF, 16, 15,  16};
    vecs[17] = '{16'h1000,  1,  1, -14};

    bus.i_start_sn2bn = 1'b0;
    bus.i_stop_sn2bn  = 1'b0;
    bus.i_sn_bit      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", int'(bus.o_busy_sn2bn), 0);
    chk("reset_valid", int'(bus.o_valid_sn2bn), 0);
    chk_outs("reset", 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Each window is followed by a stop during DONE, as the generator is driven.
    for (int v = 0; v < 18; v++) begin
      run_window(vecs[v].bits, vecs[v].cnt, vecs[v].sat, vecs[v].bip, $sformatf("vec%0d", v));
      bus.i_stop_sn2bn = 1'b1;
      @(posedge clk); #1;
      bus.i_stop_sn2bn = 1'b0;
      chk($sformatf("vec%0d_valid_one_cycle", v), int'(bus.o_valid_sn2bn), 0);
    end

    // Abort: 8 ones then stop on the 9th sample slot; last result must hold.
    bus.i_start_sn2bn = 1'b1;
    @(posedge clk); #1;
    bus.i_start_sn2bn = 1'b0;
    bus.i_sn_bit = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("abort_busy_before", int'(bus.o_busy_sn2bn), 1);
    bus.i_stop_sn2bn = 1'b1;
    @(posedge clk); #1;
    bus.i_stop_sn2bn = 1'b0;
    chk("abort_busy_after", int'(bus.o_busy_sn2bn), 0);
    idle_cycles(20, 1'b1, "abort");
    chk_outs("abort_hold", 1, 1, -14);
    run_window(16'h5555, 8, 8, 0, "alt");

    // Restart mid-window: 5 ones, then start again; only the second window reports.
    bus.i_start_sn2bn = 1'b1;
    @(posedge clk); #1;
    bus.i_start_sn2bn = 1'b0;
    bus.i_sn_bit = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("restart_no_valid", int'(bus.o_valid_sn2bn), 0);
    run_window(16'h0007, 3, 3, -10, "restart");
    @(posedge clk); #1;
    chk("restart_single_valid", int'(bus.o_valid_sn2bn), 0);

    // Start and stop together: stop wins, both from IDLE and from COUNT.
    bus.i_start_sn2bn = 1'b1;
    bus.i_stop_sn2bn  = 1'b1;
    @(posedge clk); #1;
    bus.i_start_sn2bn = 1'b0;
    bus.i_stop_sn2bn  = 1'b0;
    idle_cycles(18, 1'b1, "startstop_idle");
    bus.i_start_sn2bn = 1'b1;
    @(posedge clk); #1;
    bus.i_stop_sn2bn = 1'b1;
    @(posedge clk); #1;
    bus.i_start_sn2bn = 1'b0;
    bus.i_stop_sn2bn  = 1'b0;
    idle_cycles(18, 1'b0, "startstop_count");
    chk_outs("startstop_hold", 3, 3, -10);

    // Back-to-back: start asserted in the DONE cycle of the first window.
    run_window(16'h000F, 4, 4, -8, "b2b_a");
    begin
      int first_valid;
      first_valid = last_valid;
      run_window(16'h0FFF, 12, 12, 8, "b2b_b");
      chk("b2b_spacing", last_valid - first_valid, 17);
    end
    @(posedge clk); #1;

    // Asynchronous reset mid-window, then counting requires a fresh start.
    bus.i_start_sn2bn = 1'b1;
    @(posedge clk); #1;
    bus.i_start_sn2bn = 1'b0;
    bus.i_sn_bit = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_busy", int'(bus.o_busy_sn2bn), 0);
    chk("rst_async_valid", int'(bus.o_valid_sn2bn), 0);
    chk_outs("rst_async", 0, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycles(20, 1'b1, "rst_nostart");
    chk_outs("rst_nostart", 0, 0, 0);
    run_window(16'h0101, 2, 2, -12, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule

`default_nettype wire

// File: doc/sn2bn_counter.md
Name: sn2bn_counter

Overview:
Stochastic-to-binary converter directly downstream of the FSM_MUX stochastic number generator. It consumes the serial stochastic bit stream (o_sn_bit) over a fixed window of SN_LEN cycles, counts the ones, and presents the binary result in three formats: unipolar raw count, saturated N-bit value, and bipolar signed value. It uses the same start/stop framing as the generator, so both blocks can share one control FSM.

Parameters:
SN_LEN, 16, stream window length in cycles; must be a power of two and at least 2
BN_W, 4, width of the saturated binary output; matches the generator's binary input width
CNT_W, $clog2(SN_LEN)+1, raw count width; holds 0..SN_LEN (derived, not overridden)

Ports:
i_clk_sn2bn  input  1  clock; all logic is rising-edge
i_rst_n_sn2bn  input  1  reset; asynchronous, active-low
i_start_sn2bn  input  1  one-cycle pulse aligned with the generator's start; opens a window
i_stop_sn2bn  input  1  abort; discards the window in progress
i_sn_bit  input  1  serial stochastic bit from FSM_MUX
o_busy_sn2bn  output  1  high while a window is being counted
o_valid_sn2bn  output  1  one-cycle pulse when a new result is registered
o_bn_cnt  output  CNT_W  raw count of ones, 0..SN_LEN
o_bn_sat  output  BN_W  min(count, 2^BN_W-1)
o_bn_bip  output  CNT_W+1  signed two's complement, 2*count - SN_LEN

Behaviour:
- Reset: asynchronous, active-low. State=IDLE; internal count=0; internal idx=0; all outputs 0.
- States:
  - IDLE to COUNT on start.
  - COUNT to DONE after SN_LEN samples.
  - DONE to IDLE, or DONE to COUNT when start is high in DONE.
- Window timing:
  - Start is sampled high at edge k.
  - i_sn_bit is sampled at edges k+1 through k+SN_LEN, one bit per edge, with no gaps.
  - At edge k+SN_LEN, the final sum is registered into o_bn_cnt, o_bn_sat and o_bn_bip, the state becomes DONE and o_valid=1.
  - Latency from start to valid is SN_LEN cycles.
- COUNT:
  - On each edge: count <= count + i_sn_bit and idx <= idx + 1.
  - When idx==SN_LEN-1, the next state is DONE.
  - The final sum includes the current bit; this sum is computed combinationally and fed to the output registers.
  - The count never exceeds SN_LEN, because CNT_W bits are enough and no wrap-around is possible.
- o_busy is 1 exactly in COUNT.
- o_valid is 1 exactly in DONE (a single cycle).
- Result outputs hold their last value until the next completed window. They are not cleared on start or stop; only reset clears them.
- Arithmetic:
  - o_bn_sat = (count > 2^BN_W-1) ? 2^BN_W-1 : count[BN_W-1:0].
  - o_bn_bip = {1'b0,count,1'b0}[CNT_W:0] - SN_LEN, in signed CNT_W+1 bits. For SN_LEN=16 the range is -16..+16.
- Simultaneous and boundary events:
  - stop and start together, in any state: stop wins. Next state is IDLE, count=0, no valid.
  - stop in COUNT: abort to IDLE. Count and idx clear, o_valid stays 0, outputs unchanged.
  - start in COUNT (no stop): restart. count=0 and idx=0 at that edge, and the window restarts from the next edge.
  - start in DONE: back-to-back windows. Go to COUNT, with the first sample taken on the following edge.
  - stop in IDLE or DONE: go to (or stay in) IDLE. A valid pulse already in DONE still completes its one cycle.
  - i_sn_bit is ignored outside COUNT.
  - Reset asserted mid-window: immediate return to IDLE with all outputs 0. After reset release, a start is required before any counting.

Test Plan:
1. Reset, then start with i_sn_bit=0 for 16 cycles -> o_valid pulse at edge start+16. o_bn_cnt=0, o_bn_sat=0, o_bn_bip=-16.
2. Drive from FSM_MUX with x=0..15 in turn (start, 16 bits, then stop, as the generator is driven) -> o_bn_cnt=x and o_bn_sat=x for each x. o_bn_bip=2x-16, e.g. x=8 gives 0.
3. Start with i_sn_bit=1 for all 16 cycles -> o_bn_cnt=16, o_bn_sat=15 (saturated), o_bn_bip=+16.
4. Start, 8 ones, then stop at cycle 9 -> o_valid never asserts, o_busy drops, outputs keep the previous result. A following start with an alternating 1010 pattern gives o_bn_cnt=8.
5. Start, 5 ones, then start again mid-window, then 16 cycles with 3 ones -> exactly one o_valid, with o_bn_cnt=3. Start plus stop together -> IDLE, no valid.
6. Back-to-back: start during the DONE cycle, two windows with 4 and 12 ones -> valid pulses exactly 17 cycles apart with counts 4 and 12. Reset mid-window -> all outputs 0 asynchronously, o_busy=0.
